// File: rtl/axi_pkg.sv
// Shared AXI read-side types: AR attribute layout, fixed encodings and the line-reader FSM states.
package axi_pkg;

  localparam logic [1:0] BURST_INCR                  = 2'b01;
  localparam logic [3:0] CACHE_BUFFERABLE_MODIFIABLE = 4'b0011;

  // Width-independent part of the AR channel; address and ID widths vary per port.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
  } axi_ar_attr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_WAIT_OS,
    ST_ARV,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/axi_burst_split.sv
// Combinational burst sizer: min(beats left, MAX_BURST, beats to the next 4 KB boundary).
// Terms are 13 bits wide so a full 4096-byte distance is representable.
module axi_burst_split #(
  parameter int DATA_BYTES = 4,
  parameter int MAX_BURST  = 256
) (
  input  logic [11:0] i_addr_lo,
  input  logic [12:0] i_beats_left,
  output logic [12:0] o_beats,
  output logic [7:0]  o_len
);

  localparam int          SIZE_LOG2 = $clog2(DATA_BYTES);
  localparam logic [12:0] MAX_B     = 13'(MAX_BURST);

  logic [12:0] w_to4k;
  logic [12:0] w_min;

  always_comb begin
    w_to4k  = (13'd4096 - {1'b0, i_addr_lo}) >> SIZE_LOG2;
    w_min   = (i_beats_left < MAX_B) ? i_beats_left : MAX_B;
    o_beats = (w_to4k < w_min) ? w_to4k : w_min;
    o_len   = 8'(o_beats - 13'd1);
  end

endmodule

// File: rtl/axi_line_reader.sv
// Scan-out AR generator: each line_req rising edge issues one video line of 4 KB-safe INCR bursts,
// throttled by outstanding bursts; vga_vs low rewinds to frame_base and abandons a line in flight.
module axi_line_reader
  import axi_pkg::*;
#(
  parameter int ADDR_W          = 29,
  parameter int ID_W            = 2,
  parameter int DATA_BYTES      = 4,
  parameter int LINE_BEATS      = 640,
  parameter int MAX_BURST       = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LINE_STRIDE     = 2560,
  parameter int FRAME_LINES     = 480
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              vga_vs,
  input  logic              line_req,
  input  logic [ADDR_W-1:0] frame_base,
  output logic [ID_W-1:0]   M_AXI_ARID,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [7:0]        M_AXI_ARLEN,
  output logic [2:0]        M_AXI_ARSIZE,
  output logic [1:0]        M_AXI_ARBURST,
  output logic              M_AXI_ARLOCK,
  output logic [3:0]        M_AXI_ARCACHE,
  output logic [2:0]        M_AXI_ARPROT,
  output logic [3:0]        M_AXI_ARQOS,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic              M_AXI_RVALID,
  input  logic              M_AXI_RREADY,
  input  logic              M_AXI_RLAST,
  output logic              busy,
  output logic              line_done,
  output logic              err_overrun
);

  localparam int SIZE_LOG2 = $clog2(DATA_BYTES);
  localparam int LCNT_W    = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [1:0]        r_req_sh;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_addr;
  logic [12:0]       r_beats_left;
  logic [ADDR_W-1:0] r_araddr;
  logic [7:0]        r_arlen;
  logic              r_arvalid;
  logic [3:0]        r_os_cnt;
  logic [LCNT_W-1:0] r_line_cnt;
  logic              r_abort;
  logic              r_err_overrun;

  logic              w_start;
  logic              w_ar_hs;
  logic              w_rlast;
  logic              w_slot_free;
  logic              w_issue;
  logic [12:0]       w_beats;
  logic [7:0]        w_len;
  axi_ar_attr_t      w_ar;

  assign w_start     = (r_req_sh == 2'b01);
  assign w_ar_hs     = r_arvalid & M_AXI_ARREADY;
  assign w_rlast     = M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST;
  assign w_slot_free = (r_os_cnt < 4'(MAX_OUTSTANDING));

  axi_burst_split #(
    .DATA_BYTES(DATA_BYTES),
    .MAX_BURST (MAX_BURST)
  ) u_split (
    .i_addr_lo   (r_addr[11:0]),
    .i_beats_left(r_beats_left),
    .o_beats     (w_beats),
    .o_len       (w_len)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_CALC;
      ST_CALC, ST_WAIT_OS: begin
        if (!vga_vs) begin
          w_state_nxt = ST_IDLE;
        end else if (w_slot_free) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_ARV;
        end else begin
          w_state_nxt = ST_WAIT_OS;
        end
      end
      // An issued AR is never withdrawn; a vsync abort takes effect after its handshake.
      ST_ARV: begin
        if (M_AXI_ARREADY) begin
          if (r_abort || !vga_vs)        w_state_nxt = ST_IDLE;
          else if (r_beats_left == '0)   w_state_nxt = ST_DONE;
          else                           w_state_nxt = ST_CALC;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_req_sh      <= '0;
      r_line_base   <= '0;
      r_addr        <= '0;
      r_beats_left  <= '0;
      r_araddr      <= '0;
      r_arlen       <= '0;
      r_arvalid     <= 1'b0;
      r_os_cnt      <= '0;
      r_line_cnt    <= '0;
      r_abort       <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_req_sh <= vga_vs ? {r_req_sh[0], line_req} : 2'b00;

      if (r_state == ST_IDLE && w_start) begin
        r_addr       <= r_line_base;
        r_beats_left <= 13'(LINE_BEATS);
      end else if (w_issue) begin
        r_addr       <= r_addr + (ADDR_W'(w_beats) << SIZE_LOG2);
        r_beats_left <= r_beats_left - w_beats;
      end

      if (w_issue) begin
        r_araddr  <= r_addr;
        r_arlen   <= w_len;
        r_arvalid <= 1'b1;
      end else if (w_ar_hs) begin
        r_arvalid <= 1'b0;
      end

      if (w_ar_hs && !w_rlast)
        r_os_cnt <= r_os_cnt + 4'd1;
      else if (!w_ar_hs && w_rlast && r_os_cnt != 4'd0)
        r_os_cnt <= r_os_cnt - 4'd1;

      if (r_state == ST_IDLE) r_abort <= 1'b0;
      else if (!vga_vs)       r_abort <= 1'b1;

      if (r_state == ST_IDLE && !vga_vs) begin
        r_line_base <= frame_base;
        r_line_cnt  <= '0;
      end else if (r_state == ST_DONE) begin
        if (r_line_cnt == LCNT_W'(FRAME_LINES - 1)) begin
          r_line_base <= frame_base;
          r_line_cnt  <= '0;
        end else begin
          r_line_base <= r_line_base + ADDR_W'(LINE_STRIDE);
          r_line_cnt  <= r_line_cnt + LCNT_W'(1);
        end
      end

      if (r_state == ST_IDLE && !vga_vs)     r_err_overrun <= 1'b0;
      else if (w_start && r_state != ST_IDLE) r_err_overrun <= 1'b1;
    end
  end

  always_comb begin
    w_ar       = '0;
    w_ar.len   = r_arlen;
    w_ar.size  = 3'(SIZE_LOG2);
    w_ar.burst = BURST_INCR;
    w_ar.cache = CACHE_BUFFERABLE_MODIFIABLE;
  end

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = r_araddr;
  assign M_AXI_ARLEN   = w_ar.len;
  assign M_AXI_ARSIZE  = w_ar.size;
  assign M_AXI_ARBURST = w_ar.burst;
  assign M_AXI_ARLOCK  = w_ar.lock;
  assign M_AXI_ARCACHE = w_ar.cache;
  assign M_AXI_ARPROT  = w_ar.prot;
  assign M_AXI_ARQOS   = w_ar.qos;
  assign M_AXI_ARVALID = r_arvalid;

  assign busy        = (r_state != ST_IDLE);
  assign line_done   = (r_state == ST_DONE);
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_axi_line_reader.sv
// Directed bench for axi_line_reader with MAX_OUTSTANDING=2 and FRAME_LINES=3.
`timescale 1ns/1ps
module tb_axi_line_reader;

  localparam int ADDR_W = 29;
  localparam int ID_W   = 2;

  logic              clk_i = 1'b0;
  logic              reset;
  logic              vga_vs;
  logic              line_req;
  logic [ADDR_W-1:0] frame_base;
  logic [ID_W-1:0]   M_AXI_ARID;
  logic [ADDR_W-1:0] M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_ARLOCK;
  logic [3:0]        M_AXI_ARCACHE;
  logic [2:0]        M_AXI_ARPROT;
  logic [3:0]        M_AXI_ARQOS;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic              M_AXI_RVALID = 1'b0;
  logic              M_AXI_RREADY = 1'b0;
  logic              M_AXI_RLAST  = 1'b0;
  logic              busy;
  logic              line_done;
  logic              err_overrun;

  axi_line_reader #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_BYTES(4), .LINE_BEATS(640), .MAX_BURST(256),
    .MAX_OUTSTANDING(2), .LINE_STRIDE(2560), .FRAME_LINES(3)
  ) dut (
    .clk_i(clk_i), .reset(reset), .vga_vs(vga_vs), .line_req(line_req), .frame_base(frame_base),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RLAST(M_AXI_RLAST),
    .busy(busy), .line_done(line_done), .err_overrun(err_overrun)
  );

  always #5 clk_i = ~clk_i;

  int          errors   = 0;
  int          checks   = 0;
  int          done_cnt = 0;
  int          pend     = 0;
  int          r_sent   = 0;
  int          r_grant  = 0;
  bit          auto_r   = 1'b0;
  logic [31:0] q_addr[$];
  logic [7:0]  q_len[$];

  // Records AR handshakes (they complete at the next rising edge) and returns RLASTs on demand.
  always @(negedge clk_i) begin
    if (M_AXI_ARVALID === 1'b1 && M_AXI_ARREADY === 1'b1) begin
      q_addr.push_back(32'(M_AXI_ARADDR));
      q_len.push_back(M_AXI_ARLEN);
      pend++;
    end
    if (line_done === 1'b1) done_cnt++;
    if (pend > 0 && (auto_r || r_sent < r_grant)) begin
      M_AXI_RVALID = 1'b1; M_AXI_RREADY = 1'b1; M_AXI_RLAST = 1'b1;
      pend--;
      r_sent++;
    end else begin
      M_AXI_RVALID = 1'b0; M_AXI_RREADY = 1'b0; M_AXI_RLAST = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_ar(input string tag, input int idx, input logic [31:0] addr, input logic [7:0] len);
    check({tag, " present"}, 32'(q_addr.size() > idx), 32'd1);
    if (q_addr.size() > idx) begin
      check({tag, " addr"}, q_addr[idx], addr);
      check({tag, " len"}, 32'(q_len[idx]), 32'(len));
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk_i);
    while (busy !== 1'b0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " reaches idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_arvalid(input string tag);
    int n = 0;
    @(negedge clk_i);
    while (M_AXI_ARVALID !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check({tag, " arvalid seen"}, 32'(M_AXI_ARVALID), 32'd1);
  endtask

  task automatic pulse_req();
    line_req = 1'b1;
    step();
    step();
    line_req = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int i0;
    int bad;
    logic [31:0] wrap_base[4];
    wrap_base[0] = 32'h100000; wrap_base[1] = 32'h100A00;
    wrap_base[2] = 32'h101400; wrap_base[3] = 32'h100000;

    reset = 1'b1; vga_vs = 1'b0; line_req = 1'b0; frame_base = '0; M_AXI_ARREADY = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk_i);
    check("reset arvalid", 32'(M_AXI_ARVALID), 32'd0);
    check("reset araddr", 32'(M_AXI_ARADDR), 32'd0);
    check("reset arlen", 32'(M_AXI_ARLEN), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset line_done", 32'(line_done), 32'd0);
    check("reset err_overrun", 32'(err_overrun), 32'd0);
    check("arid", 32'(M_AXI_ARID), 32'd0);
    check("arsize", 32'(M_AXI_ARSIZE), 32'd2);
    check("arburst", 32'(M_AXI_ARBURST), 32'd1);
    check("arcache", 32'(M_AXI_ARCACHE), 32'd3);
    check("arlock/prot/qos", {M_AXI_ARLOCK, M_AXI_ARPROT, M_AXI_ARQOS}, 32'd0);

    // Line 0: edge raised in cycle N, ARVALID must appear in cycle N+3.
    step();
    vga_vs = 1'b1; M_AXI_ARREADY = 1'b1;
    step(); step();
    line_req = 1'b1;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    check("line0 arvalid at N+2", 32'(M_AXI_ARVALID), 32'd0);
    check("line0 busy in calc", 32'(busy), 32'd1);
    @(posedge clk_i); @(negedge clk_i);
    check("line0 arvalid at N+3", 32'(M_AXI_ARVALID), 32'd1);
    check("line0 first araddr", 32'(M_AXI_ARADDR), 32'h0);
    check("line0 first arlen", 32'(M_AXI_ARLEN), 32'd255);
    step();
    line_req = 1'b0;

    // Outstanding limit of 2 with no RLAST returned.
    repeat (6) @(negedge clk_i);
    step();
    check("os limit ar count", 32'(q_addr.size()), 32'd2);
    bad = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (M_AXI_ARVALID !== 1'b0) bad++;
    end
    check("wait_os arvalid low", 32'(bad), 32'd0);
    check("wait_os busy", 32'(busy), 32'd1);
    step();
    r_grant = r_sent + 1;
    wait_arvalid("third burst after rlast");
    wait_idle("line0");
    step();
    check("line0 ar count", 32'(q_addr.size()), 32'd3);
    expect_ar("line0 ar0", 0, 32'h000, 8'd255);
    expect_ar("line0 ar1", 1, 32'h400, 8'd255);
    expect_ar("line0 ar2", 2, 32'h800, 8'd127);
    check("line0 line_done pulses", 32'(done_cnt), 32'd1);

    // Line 1 crosses 4 KB at 0x1000.
    auto_r = 1'b1;
    i0 = q_addr.size();
    pulse_req();
    wait_idle("line1");
    step();
    check("line1 ar count", 32'(q_addr.size() - i0), 32'd3);
    expect_ar("line1 ar0", i0, 32'hA00, 8'd255);
    expect_ar("line1 ar1", i0 + 1, 32'hE00, 8'd127);
    expect_ar("line1 ar2", i0 + 2, 32'h1000, 8'd255);
    check("line1 line_done pulses", 32'(done_cnt), 32'd2);

    // ARREADY stall with vsync falling mid-burst.
    M_AXI_ARREADY = 1'b0;
    i0 = q_addr.size();
    pulse_req();
    wait_arvalid("stall");
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        vga_vs = 1'b0;
        frame_base = 29'h100000;
      end
      if (M_AXI_ARVALID !== 1'b1 || M_AXI_ARADDR !== 29'h1400 || M_AXI_ARLEN !== 8'd255) bad++;
      @(negedge clk_i);
    end
    check("stall ar stable", 32'(bad), 32'd0);
    M_AXI_ARREADY = 1'b1;
    wait_idle("stall abort");
    repeat (4) step();
    check("stall only one ar", 32'(q_addr.size() - i0), 32'd1);
    expect_ar("stall ar", i0, 32'h1400, 8'd255);
    check("stall no line_done", 32'(done_cnt), 32'd2);
    vga_vs = 1'b1;
    step();

    // Frame wrap after 3 lines, starting from the rewound frame_base.
    for (int k = 0; k < 4; k++) begin
      i0 = q_addr.size();
      pulse_req();
      wait_idle("wrap line");
      step();
      check($sformatf("wrap line%0d ar count", k), 32'(q_addr.size() - i0), 32'd3);
      expect_ar($sformatf("wrap line%0d start", k), i0, wrap_base[k], 8'd255);
    end
    check("wrap line_done pulses", 32'(done_cnt), 32'd6);

    // Second request edge while the line is still running.
    i0 = q_addr.size();
    line_req = 1'b1;
    step();
    line_req = 1'b0;
    step(); step();
    line_req = 1'b1;
    step(); step();
    line_req = 1'b0;
    wait_idle("overrun line");
    step();
    check("overrun flag set", 32'(err_overrun), 32'd1);
    check("overrun ar count", 32'(q_addr.size() - i0), 32'd3);
    expect_ar("overrun start", i0, 32'h100A00, 8'd255);
    check("overrun line_done pulses", 32'(done_cnt), 32'd7);
    vga_vs = 1'b0;
    repeat (3) step();
    @(negedge clk_i);
    check("overrun cleared by vsync", 32'(err_overrun), 32'd0);
    check("idle after vsync", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
